// File: rtl/mem_hs_pkg.sv
// Shared definitions for the memory wait-state responder: state encoding
// and default geometry/latency constants.
package mem_hs_pkg;

    // 2'b11 is never entered; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_READY  = 2'b10
    } state_e;

    localparam int DEF_DW      = 8;
    localparam int DEF_AW      = 4;
    localparam int DEF_LATENCY = 2;
    localparam int DEF_CW      = 4;

endpackage

// File: rtl/mem_array.sv
// Local storage for the responder: 2**AW x DW words, synchronous write,
// read mux into a data register that only updates on a load strobe.
// The storage has no reset; only the output register does.
module mem_array #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          load,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Storage write; a same-edge load reads the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register only changes when the FSM asks for a load.
    always_comb begin
        rdata_d = rdata_q;
        if (load) begin
            rdata_d = mem[raddr];
        end
    end

    // Output data register, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_wait_responder.sv
// Memory-side responder of the go/read/wait-state/done handshake.
// Handshake: rd is held high by the initiator for the whole request; ws=1
// means data is not ready and the initiator retries; rvalid=1 means rdata
// is valid and held until the initiator pulses ds for one cycle. Dropping
// rd (with ds low) before ds aborts the access. All outputs are registered.
module mem_wait_responder
    import mem_hs_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int LATENCY = DEF_LATENCY,
    parameter int CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          ds,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic          ws,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    state_e        state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [AW-1:0] cap_addr_d, cap_addr_q;
    logic          ws_d, ws_q;
    logic          rvalid_d, rvalid_q;
    logic          busy_d, busy_q;
    logic          load;
    logic [AW-1:0] raddr;

    // Next-state, latency counter and address capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_addr_d = cap_addr_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd) begin
                    cap_addr_d = addr;
                    if (LATENCY == 0) begin
                        state_d = ST_READY;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = CW'(LATENCY);
                    end
                end
            end
            ST_ACCESS: begin
                if (!rd) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_READY: begin
                // ds has priority; rd low without ds is an abort.
                if (ds || !rd) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The first request cycle reads the live address; later loads use the capture.
    always_comb begin
        raddr = (state_q == ST_IDLE) ? addr : cap_addr_q;
    end

    // Moore outputs decoded from the next state so they register with it.
    always_comb begin
        ws_d     = (state_d == ST_ACCESS);
        rvalid_d = (state_d == ST_READY);
        busy_d   = (state_d != ST_IDLE);
    end

    // FSM state, counter, captured address and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cap_addr_q <= '0;
            ws_q       <= 1'b0;
            rvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_addr_q <= cap_addr_d;
            ws_q       <= ws_d;
            rvalid_q   <= rvalid_d;
            busy_q     <= busy_d;
        end
    end

    mem_array #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .load  (load),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign ws        = ws_q;
    assign rvalid    = rvalid_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Bench for mem_wait_responder: four instances with LATENCY 0, 2, 3 and 4
// share clock and reset; each read transaction is planned up front and its
// cycle-by-cycle outputs are derived from the transaction's timing rules.
module tb_mem_wait_responder;

    logic       clk;
    logic       rst_n;
    logic       rd_a    [4];
    logic       ds_a    [4];
    logic [3:0] addr_a  [4];
    logic       we_a    [4];
    logic [3:0] waddr_a [4];
    logic [7:0] wdata_a [4];
    logic       ws_a    [4];
    logic [7:0] rdata_a [4];
    logic       rvalid_a[4];
    logic       busy_a  [4];
    logic [1:0] dbg_a   [4];

    logic [7:0] ref_mem  [4][16];
    logic [7:0] last_rd  [4];
    int checks;
    int errors;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_wait_responder #(
            .DW      (8),
            .AW      (4),
            .LATENCY ((g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 4),
            .CW      (4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst_n),
            .rd        (rd_a[g]),
            .ds        (ds_a[g]),
            .addr      (addr_a[g]),
            .we        (we_a[g]),
            .waddr     (waddr_a[g]),
            .wdata     (wdata_a[g]),
            .ws        (ws_a[g]),
            .rdata     (rdata_a[g]),
            .rvalid    (rvalid_a[g]),
            .busy      (busy_a[g]),
            .dbg_state (dbg_a[g])
        );
    end

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? 3 : 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 4; k++) begin
            rd_a[k] = 1'b0; ds_a[k] = 1'b0; addr_a[k] = '0;
            we_a[k] = 1'b0; waddr_a[k] = '0; wdata_a[k] = '0;
        end
    endtask

    task automatic check_out(input string name, input int k, input int n,
                             input logic e_ws, input logic e_rv,
                             input logic e_busy, input logic [7:0] e_rd);
        checks++;
        if (ws_a[k] !== e_ws) begin
            errors++;
            $display("FAIL %s ws inst=%0d cyc=%0d got=%b exp=%b", name, k, n, ws_a[k], e_ws);
        end
        checks++;
        if (rvalid_a[k] !== e_rv) begin
            errors++;
            $display("FAIL %s rvalid inst=%0d cyc=%0d got=%b exp=%b", name, k, n, rvalid_a[k], e_rv);
        end
        checks++;
        if (busy_a[k] !== e_busy) begin
            errors++;
            $display("FAIL %s busy inst=%0d cyc=%0d got=%b exp=%b", name, k, n, busy_a[k], e_busy);
        end
        checks++;
        if (rdata_a[k] !== e_rd) begin
            errors++;
            $display("FAIL %s rdata inst=%0d cyc=%0d got=%h exp=%h", name, k, n, rdata_a[k], e_rd);
        end
    endtask

    // Driver: one-cycle write, mirrored into the reference memory.
    task automatic write_mem(input int k, input logic [3:0] a, input logic [7:0] d);
        we_a[k] = 1'b1; waddr_a[k] = a; wdata_a[k] = d;
        tick();
        ref_mem[k][a] = d;
        we_a[k] = 1'b0;
    endtask

    // Driver + model: one read request. abort_at<0 means completed with ds
    // after 'hold' extra READY cycles; otherwise rd drops at cycle abort_at.
    // wcyc>=0 places one write at that cycle (cycle 0 = first rd cycle).
    task automatic run_read(input string name, input int k, input logic [3:0] a,
                            input int hold, input int abort_at, input int wcyc,
                            input logic [3:0] wa, input logic [7:0] wd);
        int lat, end_c;
        bit aborted, loaded;
        logic [7:0] exp_data;
        lat      = lat_of(k);
        aborted  = (abort_at >= 1);
        end_c    = aborted ? abort_at : lat + 1 + hold;
        loaded   = (end_c > lat);
        exp_data = last_rd[k];
        for (int c = 0; c <= end_c; c++) begin
            int n;
            rd_a[k]   = !(aborted && c == end_c);
            ds_a[k]   = !aborted && c == end_c;
            addr_a[k] = (c == 0) ? a : 4'($urandom_range(0, 15));
            if (c == wcyc) begin
                we_a[k] = 1'b1; waddr_a[k] = wa; wdata_a[k] = wd;
            end else begin
                we_a[k] = 1'b0; waddr_a[k] = 4'($urandom_range(0, 15));
                wdata_a[k] = 8'($urandom_range(0, 255));
            end
            // The load at the end of cycle lat sees memory before that cycle's write.
            if (loaded && c == lat) exp_data = ref_mem[k][a];
            if (c == wcyc) ref_mem[k][wa] = wd;
            tick();
            n = c + 1;
            if (n <= end_c)
                check_out(name, k, n, n <= lat, n > lat, 1'b1,
                          (n > lat) ? exp_data : last_rd[k]);
            else
                check_out(name, k, n, 1'b0, 1'b0, 1'b0,
                          loaded ? exp_data : last_rd[k]);
        end
        if (loaded) last_rd[k] = exp_data;
        rd_a[k] = 1'b0; ds_a[k] = 1'b0; we_a[k] = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        for (int k = 0; k < 4; k++) begin
            last_rd[k] = '0;
            check_out("reset", k, 0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 16; a++)
                write_mem(k, 4'(a), 8'($urandom_range(0, 255)));
    endtask

    task automatic test_lat0();
        write_mem(0, 4'd3, 8'hA5);
        run_read("lat0", 0, 4'd3, 1, -1, -1, 4'd0, 8'h00);
    endtask

    task automatic test_lat3();
        write_mem(2, 4'd7, 8'h3C);
        run_read("lat3", 2, 4'd7, 2, -1, -1, 4'd0, 8'h00);
    endtask

    task automatic test_abort();
        run_read("abort", 3, 4'd9, 0, 2, -1, 4'd0, 8'h00);
        run_read("after_abort", 3, 4'd6, 1, -1, -1, 4'd0, 8'h00);
        run_read("ready_abort", 3, 4'd2, 0, 6, -1, 4'd0, 8'h00);
    endtask

    task automatic test_write_collision();
        write_mem(1, 4'd5, 8'h11);
        run_read("wr_same_edge", 1, 4'd5, 1, -1, 2, 4'd5, 8'h22);
        checks++;
        if (last_rd[1] !== 8'h11) begin
            errors++;
            $display("FAIL wr_same_edge_model got=%h exp=11", last_rd[1]);
        end
        write_mem(1, 4'd5, 8'h11);
        run_read("wr_during_access", 1, 4'd5, 1, -1, 1, 4'd5, 8'h22);
        checks++;
        if (rdata_a[1] !== 8'h22) begin
            errors++;
            $display("FAIL wr_during_access_final got=%h exp=22", rdata_a[1]);
        end
    endtask

    task automatic test_async_reset();
        rd_a[1] = 1'b1; addr_a[1] = 4'd4;
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (rvalid_a[1] !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_ready got=%b exp=1", rvalid_a[1]);
        end
        #3 rst_n = 1'b0;
        #1;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            last_rd[k] = '0;
            check_out("async_reset", k, 0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        #2 rst_n = 1'b1;
        tick();
        run_read("post_reset", 1, 4'd0, 1, -1, -1, 4'd0, 8'h00);
    endtask

    task automatic test_back_to_back();
        write_mem(1, 4'd1, 8'h01);
        write_mem(1, 4'd2, 8'h02);
        run_read("b2b_first", 1, 4'd1, 1, -1, -1, 4'd0, 8'h00);
        checks++;
        if (rdata_a[1] !== 8'h01) begin
            errors++;
            $display("FAIL b2b_first_data got=%h exp=01", rdata_a[1]);
        end
        run_read("b2b_second", 1, 4'd2, 1, -1, -1, 4'd0, 8'h00);
        checks++;
        if (rdata_a[1] !== 8'h02) begin
            errors++;
            $display("FAIL b2b_second_data got=%h exp=02", rdata_a[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int k, lat, hold, abort_at, wcyc, gap;
            logic [3:0] a, wa;
            k    = $urandom_range(0, 3);
            lat  = lat_of(k);
            a    = 4'($urandom_range(0, 15));
            hold = $urandom_range(0, 3);
            abort_at = -1;
            if ($urandom_range(0, 3) == 0) abort_at = $urandom_range(1, lat + 2);
            wcyc = ($urandom_range(0, 1) == 1) ? $urandom_range(0, lat + 1) : -1;
            wa   = ($urandom_range(0, 1) == 1) ? a : 4'($urandom_range(0, 15));
            run_read("random", k, a, hold, abort_at, wcyc, wa, 8'($urandom_range(0, 255)));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                write_mem(k, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                check_out("random_gap", k, g, 1'b0, 1'b0, 1'b0, last_rd[k]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lat0();
        test_lat3();
        test_abort();
        test_write_collision();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
